// File: rtl/trap_control_unit.sv
// trap_control_unit: responder side of the exception path.
// Collects exception flags and mret requests from commit, pulses
// exception_sig / mret_sig, captures mepc/mcause/mtval and redirects fetch
// to the trap vector on entry or back to mepc on return.
//
// Ports
//   clk, reset              clock, asynchronous active-low reset
//   address_exception       address out of range (address detector)
//   illegal_inst, ecall     commit-stage exception flags
//   mret_req                mret at commit
//   commit_pc, fault_addr   PC of the event, offending data address
//   exception_sig           1-cycle trap-entry pulse (flush / clear detectors)
//   mret_sig                1-cycle trap-return pulse
//   redirect_valid/_pc      1-cycle fetch redirect strobe and target
//   mepc, mcause, mtval     captured trap CSRs
//   trap_active             high from trap entry until the return completes
//   halted                  double fault, left only through reset
module trap_control_unit #(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0400,
  parameter logic [31:0] CAUSE_ILL   = 32'd2,
  parameter logic [31:0] CAUSE_ADDR  = 32'd5,
  parameter logic [31:0] CAUSE_ECALL = 32'd11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        address_exception,
  input  logic        illegal_inst,
  input  logic        ecall,
  input  logic        mret_req,
  input  logic [31:0] commit_pc,
  input  logic [31:0] fault_addr,
  output logic        exception_sig,
  output logic        mret_sig,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] mepc,
  output logic [31:0] mcause,
  output logic [31:0] mtval,
  output logic        trap_active,
  output logic        halted
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FLUSH    = 3'd1,
    S_REDIRECT = 3'd2,
    S_IN_TRAP  = 3'd3,
    S_RETURN   = 3'd4,
    S_HALT     = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   mepc_q, mepc_d;
  logic [XLEN-1:0]   mcause_q, mcause_d;
  logic [XLEN-1:0]   mtval_q, mtval_d;
  logic              exc_q, exc_d;
  logic              mret_q, mret_d;
  logic              rdv_q, rdv_d;
  logic [XLEN-1:0]   rdpc_q, rdpc_d;
  logic              active_q, active_d;
  logic              halted_q, halted_d;

  logic              any_exc_c;

  assign any_exc_c = address_exception | illegal_inst | ecall;

  // Next state, CSR capture and output values registered for the next state
  always_comb begin
    state_d  = state_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    mtval_d  = mtval_q;

    unique case (state_q)
      S_IDLE: begin
        if (any_exc_c || mret_req) begin
          state_d = S_FLUSH;
          mepc_d  = commit_pc;
          mtval_d = '0;
          // A stray mret (no exception) is handled as an illegal instruction
          if (illegal_inst || !any_exc_c) begin
            mcause_d = CAUSE_ILL;
          end else if (ecall) begin
            mcause_d = CAUSE_ECALL;
          end else begin
            mcause_d = CAUSE_ADDR;
            mtval_d  = fault_addr;
          end
        end
      end
      S_FLUSH:    state_d = S_REDIRECT;
      S_REDIRECT: state_d = S_IN_TRAP;
      S_IN_TRAP: begin
        // A fault inside the handler is fatal and keeps the original CSRs
        if (any_exc_c) begin
          state_d = S_HALT;
        end else if (mret_req) begin
          state_d = S_RETURN;
        end
      end
      S_RETURN:   state_d = S_IDLE;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it
    exc_d    = (state_d == S_FLUSH);
    mret_d   = (state_d == S_RETURN);
    rdv_d    = (state_d == S_REDIRECT) || (state_d == S_RETURN);
    active_d = (state_d != S_IDLE);
    halted_d = (state_d == S_HALT);
    rdpc_d   = '0;
    if (state_d == S_REDIRECT) begin
      rdpc_d = TRAP_VECTOR;
    end else if (state_d == S_RETURN) begin
      rdpc_d = mepc_d;
    end
  end

  // State, CSR and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
      exc_q    <= 1'b0;
      mret_q   <= 1'b0;
      rdv_q    <= 1'b0;
      rdpc_q   <= '0;
      active_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      mtval_q  <= mtval_d;
      exc_q    <= exc_d;
      mret_q   <= mret_d;
      rdv_q    <= rdv_d;
      rdpc_q   <= rdpc_d;
      active_q <= active_d;
      halted_q <= halted_d;
    end
  end

  assign exception_sig  = exc_q;
  assign mret_sig       = mret_q;
  assign redirect_valid = rdv_q;
  assign redirect_pc    = rdpc_q;
  assign mepc           = mepc_q;
  assign mcause         = mcause_q;
  assign mtval          = mtval_q;
  assign trap_active    = active_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_trap_control_unit.sv
// Directed bench for trap_control_unit: trap entry, return, cause priority,
// stray mret, double fault and reset in the middle of a trap.
module tb_trap_control_unit;

  logic        clk;
  logic        reset;
  logic        address_exception;
  logic        illegal_inst;
  logic        ecall;
  logic        mret_req;
  logic [31:0] commit_pc;
  logic [31:0] fault_addr;
  logic        exception_sig;
  logic        mret_sig;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mtval;
  logic        trap_active;
  logic        halted;

  int n_vec;
  int n_err;

  trap_control_unit dut (
    .clk               (clk),
    .reset             (reset),
    .address_exception (address_exception),
    .illegal_inst      (illegal_inst),
    .ecall             (ecall),
    .mret_req          (mret_req),
    .commit_pc         (commit_pc),
    .fault_addr        (fault_addr),
    .exception_sig     (exception_sig),
    .mret_sig          (mret_sig),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .mepc              (mepc),
    .mcause            (mcause),
    .mtval             (mtval),
    .trap_active       (trap_active),
    .halted            (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock edge, then settle so registered outputs are sampled
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic il, input logic ec, input logic mr,
                       input logic [31:0] pc, input logic [31:0] fa);
    address_exception = a;
    illegal_inst      = il;
    ecall             = ec;
    mret_req          = mr;
    commit_pc         = pc;
    fault_addr        = fa;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".exc"},    32'(exception_sig),  32'd0);
    chk({tag, ".mret"},   32'(mret_sig),       32'd0);
    chk({tag, ".rdv"},    32'(redirect_valid), 32'd0);
    chk({tag, ".rdpc"},   redirect_pc,         32'd0);
    chk({tag, ".mepc"},   mepc,                32'd0);
    chk({tag, ".mcause"}, mcause,              32'd0);
    chk({tag, ".mtval"},  mtval,               32'd0);
    chk({tag, ".active"}, 32'(trap_active),    32'd0);
    chk({tag, ".halted"}, 32'(halted),         32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle_inputs();
    reset = 1'b0;
    repeat (2) tick();
    chk_all_zero("rst");
    reset = 1'b1;
    tick();
    chk("idle.active", 32'(trap_active), 32'd0);

    // 1: address trap
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h900);
    tick();
    idle_inputs();
    chk("t1.exc",    32'(exception_sig),  32'd1);
    chk("t1.active", 32'(trap_active),    32'd1);
    chk("t1.rdv0",   32'(redirect_valid), 32'd0);
    chk("t1.mepc",   mepc,   32'h40);
    chk("t1.mcause", mcause, 32'd5);
    chk("t1.mtval",  mtval,  32'h900);
    tick();
    chk("t1.exc_drop", 32'(exception_sig),  32'd0);
    chk("t1.rdv",      32'(redirect_valid), 32'd1);
    chk("t1.rdpc",     redirect_pc,         32'h400);
    tick();
    chk("t1.intrap_rdv",    32'(redirect_valid), 32'd0);
    chk("t1.intrap_active", 32'(trap_active),    32'd1);

    // 2: return to mepc
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    tick();
    idle_inputs();
    chk("t2.mret",   32'(mret_sig),       32'd1);
    chk("t2.rdv",    32'(redirect_valid), 32'd1);
    chk("t2.rdpc",   redirect_pc,         32'h40);
    chk("t2.exc",    32'(exception_sig),  32'd0);
    chk("t2.active", 32'(trap_active),    32'd1);
    tick();
    chk("t2.mret_drop", 32'(mret_sig),       32'd0);
    chk("t2.rdv_drop",  32'(redirect_valid), 32'd0);
    chk("t2.active0",   32'(trap_active),    32'd0);

    // 3: priority with everything raised (mret too); inputs held through FLUSH
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h80, 32'h123);
    tick();
    chk("t3.exc",    32'(exception_sig), 32'd1);
    chk("t3.mret",   32'(mret_sig),      32'd0);
    chk("t3.mepc",   mepc,   32'h80);
    chk("t3.mcause", mcause, 32'd2);
    chk("t3.mtval",  mtval,  32'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hBAD0, 32'hBAD1);
    tick();
    idle_inputs();
    chk("t3.flush_ign_rdv",  32'(redirect_valid), 32'd1);
    chk("t3.flush_ign_mepc", mepc,                32'h80);
    chk("t3.flush_ign_halt", 32'(halted),         32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    tick();
    idle_inputs();
    chk("t3.ret_rdpc", redirect_pc, 32'h80);
    tick();

    // 3b: ecall beats address exception
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'hC0, 32'h777);
    tick();
    idle_inputs();
    chk("t3b.mcause", mcause, 32'd11);
    chk("t3b.mtval",  mtval,  32'd0);
    chk("t3b.mepc",   mepc,   32'hC0);
    repeat (2) tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    tick();
    idle_inputs();
    tick();
    chk("t3b.active0", 32'(trap_active), 32'd0);

    // 4: stray mret in IDLE
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 32'h55);
    tick();
    idle_inputs();
    chk("t4.exc",    32'(exception_sig), 32'd1);
    chk("t4.mret",   32'(mret_sig),      32'd0);
    chk("t4.mcause", mcause, 32'd2);
    chk("t4.mtval",  mtval,  32'd0);
    chk("t4.mepc",   mepc,   32'h200);
    tick();
    chk("t4.mret_r", 32'(mret_sig), 32'd0);
    chk("t4.rdpc",   redirect_pc,   32'h400);
    tick();

    // 5: double fault (ecall with mret in IN_TRAP)
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h300, 32'h0);
    tick();
    idle_inputs();
    chk("t5.halted", 32'(halted),      32'd1);
    chk("t5.active", 32'(trap_active), 32'd1);
    chk("t5.mret",   32'(mret_sig),    32'd0);
    chk("t5.mepc",   mepc,   32'h200);
    chk("t5.mcause", mcause, 32'd2);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h8, 32'h9);
      tick();
      chk("t5.pulses", {29'd0, exception_sig, mret_sig, redirect_valid}, 32'd0);
      chk("t5.stay",   32'(halted), 32'd1);
    end
    idle_inputs();

    // 6: reset during REDIRECT
    reset = 1'b0;
    #1;
    chk_all_zero("t6.rst_halt");
    tick();
    reset = 1'b1;
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h44, 32'h999);
    tick();
    idle_inputs();
    tick();
    chk("t6.in_redirect", 32'(redirect_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("t6.async");
    tick();
    reset = 1'b1;
    tick();
    chk("t6.idle_active", 32'(trap_active),   32'd0);
    chk("t6.idle_exc",    32'(exception_sig), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    tick();
    idle_inputs();
    chk("t6.retrap_exc",    32'(exception_sig), 32'd1);
    chk("t6.retrap_mcause", mcause,             32'd11);
    chk("t6.retrap_mepc",   mepc,               32'h10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
